// File: rtl/ram_rw_seq_pkg.sv
// ram_rw_seq_pkg: shared types and helpers for the RAM write/read-back sequencer.
//   state_e  - sequencer FSM states
//   STATE_W  - encoded width of state_e
//   pat()    - address-derived fill pattern; the caller truncates it to the RAM data width
package ram_rw_seq_pkg;

  localparam int STATE_W = 3;
  localparam int PAT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // word[a] = (a + seed) mod 2**DATA_W once the caller truncates the result
  function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] addr,
                                           input logic [PAT_W-1:0] seed);
    return addr + seed;
  endfunction

endpackage

// File: rtl/ram_rw_seq_if.sv
// ram_rw_seq_if: both ports of the simple dual-port RAM.
//   master - sequencer side: drives the write port and the read request, receives read data
//   slave  - RAM side
interface ram_rw_seq_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;

  modport master (
    output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
    input  ram_rd_data
  );

  modport slave (
    input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
    output ram_rd_data
  );
endinterface

// File: rtl/ram_rw_chk.sv
// ram_rw_chk: read-back checker. The expected word and a valid bit travel through an
// RD_LAT-deep pipeline alongside the RAM read; where valid emerges, the read data is
// compared against it.
//   clk, rst_n     clock, async active-low reset
//   clr_i          accepted start: clears err, err_cnt and the valid pipeline
//   rd_en_i        read request as driven to the RAM
//   rd_addr_i      read address as driven to the RAM
//   seed_i         pattern offset of the current pass
//   rd_data_i      RAM read data, valid RD_LAT cycles after rd_en_i
//   err_o          sticky mismatch flag
//   err_cnt_o      mismatch count, saturating at all-ones
module ram_rw_chk
  import ram_rw_seq_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              err_o,
  output logic [ADDR_W:0]   err_cnt_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] exp_q [RD_LAT];
  logic              err_q;
  logic [ADDR_W:0]   cnt_q;
  logic              hit;

  assign hit = vld_q[RD_LAT-1] && (rd_data_i != exp_q[RD_LAT-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (clr_i) begin
      vld_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q[0] <= rd_en_i;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      if (hit) begin
        err_q <= 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the expected-data pipeline has no reset; it is only looked at when its valid
  // bit is set, and the valid bits are reset, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    exp_q[0] <= DATA_W'(pat(PAT_W'(rd_addr_i), PAT_W'(seed_i)));
    for (int i = 1; i < RD_LAT; i++) exp_q[i] <= exp_q[i-1];
  end

  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;

endmodule

// File: rtl/ram_rw_seq.sv
// ram_rw_seq: fills every RAM word with an address-derived pattern, then reads every word
// back and compares it. One FSM owns both RAM ports; all outputs are registered.
//   clk, rst_n   clock, async active-low reset (aborts a pass immediately)
//   start        1-cycle pulse, honoured in IDLE or DONE
//   ram          RAM write/read port bundle (ram_rw_seq_if.master)
//   busy         high in WRITE/GAP/READ/DRAIN
//   done         high while in DONE
//   err          sticky mismatch flag, cleared on accepted start
//   err_cnt      mismatch count of this pass, saturating at all-ones
// Build option RAM_RW_SEQ_AUTO_RESTART_EN: DONE lasts one cycle and the next pass starts
// by itself with the seed incremented; err/err_cnt then accumulate across passes and start
// is only honoured from IDLE.
module ram_rw_seq
  import ram_rw_seq_pkg::*;
#(
  parameter int          ADDR_W = 6,
  parameter int          DATA_W = 8,
  parameter int          DEPTH  = 64,
  parameter int          RD_LAT = 1,
  parameter int unsigned SEED   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  ram_rw_seq_if.master    ram,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] err_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  state_e            state_q;
  logic              wr_en_q, rd_en_q, busy_q, done_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0] wr_data_q, seed_q;
  logic [1:0]        drain_q;
  logic              start_ok;

`ifdef RAM_RW_SEQ_AUTO_RESTART_EN
  assign start_ok = start && (state_q == ST_IDLE);
`else
  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
`endif

  // NOTE: all state, including the registered outputs, is updated with non-blocking
  // assignments; the defaults below are then overridden by the case arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= '0;
      seed_q    <= DATA_W'(SEED);
    end else begin
      // Idle values: enables low, addresses parked at 0
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
`ifdef RAM_RW_SEQ_AUTO_RESTART_EN
          if (start_ok || state_q == ST_DONE) begin
            state_q   <= ST_WRITE;
            wr_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            if (state_q == ST_DONE) begin
              seed_q    <= seed_q + 1'b1;
              wr_data_q <= DATA_W'(pat('0, PAT_W'(seed_q) + 1'b1));
            end else begin
              wr_data_q <= DATA_W'(pat('0, PAT_W'(seed_q)));
            end
          end
`else
          if (start_ok) begin
            state_q   <= ST_WRITE;
            wr_en_q   <= 1'b1;
            wr_data_q <= DATA_W'(pat('0, PAT_W'(seed_q)));
            busy_q    <= 1'b1;
          end else begin
            done_q <= (state_q == ST_DONE);
          end
`endif
        end
        ST_WRITE: begin
          busy_q <= 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            state_q <= ST_GAP;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_addr_q + 1'b1;
            wr_data_q <= DATA_W'(pat(PAT_W'(wr_addr_q) + 1'b1, PAT_W'(seed_q)));
          end
        end
        // One dead cycle so the last write is committed before the first read
        ST_GAP: begin
          state_q <= ST_READ;
          rd_en_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        ST_READ: begin
          busy_q <= 1'b1;
          if (rd_addr_q == LAST_ADDR) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        // Wait out the read latency so the last word is compared before DONE
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ram_rw_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (start_ok),
    .rd_en_i   (rd_en_q),
    .rd_addr_i (rd_addr_q),
    .seed_i    (seed_q),
    .rd_data_i (ram.ram_rd_data),
    .err_o     (err),
    .err_cnt_o (err_cnt)
  );

  assign ram.ram_wr_en   = wr_en_q;
  assign ram.ram_wr_addr = wr_addr_q;
  assign ram.ram_wr_data = wr_data_q;
  assign ram.ram_rd_en   = rd_en_q;
  assign ram.ram_rd_addr = rd_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
